// File: rtl/bram_lsu_pkg.sv
// Shared types and constants for the LSU-to-BRAM bridge: FSM states, latencies
// and the word-to-slot address mapping.
package bram_lsu_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_LO,
    RD_HI,
    RD_WAIT,
    CAP_LO,
    CAP_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  localparam int unsigned WORD_W = 11;  // word index width inside the 8 KiB window
  localparam int unsigned SLOT_W = 12;  // halfword slot index width (4K slots)
  localparam int unsigned RAM_AW = 14;

  localparam int unsigned RD_LAT      = 2;
  localparam int unsigned LAT_ERR     = 1;
  localparam int unsigned LAT_LD      = 5;
  localparam int unsigned LAT_ST_FULL = 3;
  localparam int unsigned LAT_ST_RMW  = 8;

  // Word w lives in slots 2w (lo) and 2w+1 (hi); the RAM wants the slot in ad[13:2].
  function automatic logic [RAM_AW-1:0] slot_ad(input logic [WORD_W-1:0] word, input logic hi);
    return {word, hi, 2'b00};
  endfunction

endpackage

// File: rtl/bram_be_merge.sv
// Combinational byte-lane merge: each byte of the result comes from new_data
// when its enable is set, otherwise from old_data.
module bram_be_merge (
  input  logic [31:0] old_data,
  input  logic [31:0] new_data,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/bram_lsu_bridge.sv
// Bridges 32-bit LSU word loads/stores onto port A of a 4K x 16 Gowin_DPB,
// using two halfword accesses per word and read-modify-write for partial stores.
module bram_lsu_bridge
  import bram_lsu_pkg::*;
#(
  parameter int ADDR_W  = 13,
  parameter int BRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [3:0]         req_be,
  output logic               resp_valid,
  output logic               resp_err,
  output logic [31:0]        resp_rdata,
  output logic               bram_reset,
  output logic               bram_ce,
  output logic               bram_oce,
  output logic               bram_wre,
  output logic [BRAM_AW-1:0] bram_ad,
  output logic [15:0]        bram_din,
  input  logic [15:0]        bram_dout,
  output logic [2:0]         bram_blksel
);

  state_t            state;
  logic              we_q;
  logic              err_q;
  logic [ADDR_W-3:0] word_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [15:0]       cap_lo;
  logic [15:0]       cap_hi;
  logic [31:0]       merged;

  assign bram_reset  = ~rst_n;
  assign bram_oce    = 1'b1;
  assign bram_blksel = 3'b000;

  bram_be_merge u_merge (
    .old_data ({cap_hi, cap_lo}),
    .new_data (wdata_q),
    .be       (be_q),
    .merged   (merged)
  );

  // Bus outputs are loaded on the edge entering a state, so each RD_*/WR_* state
  // presents its access for its whole cycle and the RAM samples it at the state's exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      bram_ce    <= 1'b0;
      bram_wre   <= 1'b0;
      bram_ad    <= '0;
      bram_din   <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      word_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      cap_lo     <= '0;
      cap_hi     <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      bram_ce    <= 1'b0;
      bram_wre   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            word_q    <= req_addr[ADDR_W-1:2];
            wdata_q   <= req_wdata;
            be_q      <= req_be;
            err_q     <= (req_addr[1:0] != 2'b00);
            if (req_addr[1:0] != 2'b00) begin
              state <= DONE;
            end else if (!req_we || (req_be != 4'b0000 && req_be != 4'b1111)) begin
              state   <= RD_LO;
              bram_ce <= 1'b1;
              bram_ad <= slot_ad(req_addr[ADDR_W-1:2], 1'b0);
            end else if (req_be == 4'b1111) begin
              state    <= WR_LO;
              bram_ce  <= 1'b1;
              bram_wre <= 1'b1;
              bram_ad  <= slot_ad(req_addr[ADDR_W-1:2], 1'b0);
              bram_din <= req_wdata[15:0];
            end else begin
              state <= DONE;
            end
          end
        end
        RD_LO: begin
          state   <= RD_HI;
          bram_ce <= 1'b1;
          bram_ad <= slot_ad(word_q, 1'b1);
        end
        RD_HI:   state <= RD_WAIT;
        RD_WAIT: begin
          state  <= CAP_LO;
          cap_lo <= bram_dout;
        end
        CAP_LO: begin
          state  <= CAP_HI;
          cap_hi <= bram_dout;
        end
        CAP_HI: begin
          if (we_q) begin
            state    <= WR_LO;
            bram_ce  <= 1'b1;
            bram_wre <= 1'b1;
            bram_ad  <= slot_ad(word_q, 1'b0);
            bram_din <= merged[15:0];
          end else begin
            // Loads complete straight from here; the response cycle is spent in IDLE.
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b1;
            resp_rdata <= {cap_hi, cap_lo};
          end
        end
        WR_LO: begin
          // With be=1111 the merge returns wdata_q unchanged, so both store kinds share this path.
          state    <= WR_HI;
          bram_ce  <= 1'b1;
          bram_wre <= 1'b1;
          bram_ad  <= slot_ad(word_q, 1'b1);
          bram_din <= merged[31:16];
        end
        WR_HI:   state <= DONE;
        DONE: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b1;
          resp_err   <= err_q;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_lsu_bridge.sv
// Scoreboard bench for bram_lsu_bridge paired with a behavioural 4K x 16
// Gowin_DPB port-A model (registered address, registered output).
module tb_bram_lsu_bridge;
  import bram_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [12:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        bram_reset;
  logic        bram_ce;
  logic        bram_oce;
  logic        bram_wre;
  logic [13:0] bram_ad;
  logic [15:0] bram_din;
  logic [15:0] bram_dout;
  logic [2:0]  bram_blksel;

  always #5 clk = ~clk;

  bram_lsu_bridge #(.ADDR_W(13), .BRAM_AW(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .bram_reset(bram_reset), .bram_ce(bram_ce), .bram_oce(bram_oce),
    .bram_wre(bram_wre), .bram_ad(bram_ad), .bram_din(bram_din),
    .bram_dout(bram_dout), .bram_blksel(bram_blksel)
  );

  // RAM model: array has no reset; only the read pipeline responds to reseta.
  logic [15:0] mem [0:4095];
  logic [15:0] rd_q;

  always @(posedge clk)
    if (bram_ce && bram_wre) mem[bram_ad[13:2]] <= bram_din;

  always @(posedge clk or posedge bram_reset) begin
    if (bram_reset) begin
      rd_q      <= '0;
      bram_dout <= '0;
    end else begin
      if (bram_ce && !bram_wre) rd_q <= mem[bram_ad[13:2]];
      if (bram_oce) bram_dout <= rd_q;
    end
  end

  typedef struct {
    int unsigned cyc;
    logic        err;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned ce_cnt = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (bram_ce) ce_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_cycle"}, cyc, e.cyc);
        check({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
        check({e.name, "_rdata"}, resp_rdata, e.rdata);
      end
    end
  end

  // Drive one request once the bridge is ready; acceptance edge N is the next posedge.
  task automatic issue(input string name, input logic we, input logic [12:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input int unsigned lat, input logic err,
                       input logic [31:0] rdata, input bit expect_resp);
    int unsigned waited = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check({name, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check({name, "_accepted"}, {31'd0, req_ready}, 32'd0);
    if (expect_resp) begin
      e.cyc   = cyc + lat;
      e.err   = err;
      e.rdata = rdata;
      e.name  = name;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
  endtask

  int unsigned ce0;

  initial begin
    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_ce_wre", {30'd0, bram_ce, bram_wre}, 32'd0);
    check("rst_ad_din", {2'd0, bram_ad, bram_din}, 32'd0);
    check("bram_reset", {31'd0, bram_reset}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Full store then back-to-back load.
    issue("st_full", 1'b1, 13'h010, 32'hDEADBEEF, 4'b1111, LAT_ST_FULL, 1'b0, 32'h0, 1'b1);
    issue("ld_full", 1'b0, 13'h010, 32'h0, 4'b0000, LAT_LD, 1'b0, 32'hDEADBEEF, 1'b1);
    wait_idle();
    check("mem8", {16'd0, mem[8]}, 32'h0000BEEF);
    check("mem9", {16'd0, mem[9]}, 32'h0000DEAD);

    // Partial stores via read-modify-write.
    issue("st_base", 1'b1, 13'h020, 32'h11223344, 4'b1111, LAT_ST_FULL, 1'b0, 32'h0, 1'b1);
    issue("st_rmw", 1'b1, 13'h020, 32'hAABBCCDD, 4'b0101, LAT_ST_RMW, 1'b0, 32'h0, 1'b1);
    issue("ld_rmw", 1'b0, 13'h020, 32'h0, 4'b0000, LAT_LD, 1'b0, 32'h11BB33DD, 1'b1);
    issue("st_rmw_b3", 1'b1, 13'h010, 32'h77000000, 4'b1000, LAT_ST_RMW, 1'b0, 32'h0, 1'b1);
    issue("ld_rmw_b3", 1'b0, 13'h010, 32'h0, 4'b0000, LAT_LD, 1'b0, 32'h77ADBEEF, 1'b1);
    wait_idle();

    // Misaligned requests never touch the RAM.
    ce0 = ce_cnt;
    issue("ld_mis", 1'b0, 13'h013, 32'h0, 4'b0000, LAT_ERR, 1'b1, 32'h0, 1'b1);
    issue("st_mis", 1'b1, 13'h013, 32'h12345678, 4'b1111, LAT_ERR, 1'b1, 32'h0, 1'b1);
    issue("st_mis2", 1'b1, 13'h002, 32'h12345678, 4'b0011, LAT_ERR, 1'b1, 32'h0, 1'b1);
    // Empty byte-enable store is a no-op.
    issue("st_be0", 1'b1, 13'h010, 32'hFFFFFFFF, 4'b0000, LAT_ERR, 1'b0, 32'h0, 1'b1);
    wait_idle();
    check("no_ce_mis_be0", ce_cnt - ce0, 32'd0);
    issue("ld_after_be0", 1'b0, 13'h010, 32'h0, 4'b0000, LAT_LD, 1'b0, 32'h77ADBEEF, 1'b1);
    wait_idle();

    // Reset during WR_HI of a full store: lo lands, hi stays stale, no response.
    issue("st_pre", 1'b1, 13'h040, 32'h11112222, 4'b1111, LAT_ST_FULL, 1'b0, 32'h0, 1'b1);
    wait_idle();
    issue("st_abort", 1'b1, 13'h040, 32'h55667788, 4'b1111, 0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    check("abort_ce_wre", {30'd0, bram_ce, bram_wre}, 32'd0);
    check("abort_ad_din", {2'd0, bram_ad, bram_din}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_mem_lo", {16'd0, mem[32]}, 32'h00007788);
    check("abort_mem_hi", {16'd0, mem[33]}, 32'h00001111);
    issue("ld_after_abort", 1'b0, 13'h040, 32'h0, 4'b0000, LAT_LD, 1'b0, 32'h11117788, 1'b1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
